// File: rtl/fmul.sv
// fmul: iterative binary32 multiplier, radix-4 Booth, carry-save, fixed latency.
// Optional FMUL_EARLY_OUT_EN: special operands finish two cycles after accept.
module fmul (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic        busy,
  output logic        valid,
  output logic [31:0] rslt,
  output logic [4:0]  flag
);

  localparam int LAT = 15;
  localparam logic [3:0] C_IDLE = 4'd0;
  localparam logic [3:0] C_LAST = 4'd13;
  localparam logic [3:0] C_NORM = 4'd14;
  localparam logic [3:0] C_DONE = 4'(LAT);

  logic [3:0]  cnt;
  logic [23:0] ma_q;
  logic [26:0] mbr_q;
  logic [49:0] ps_q;
  logic [49:0] pc_q;
  logic [7:0]  ex_q;
  logic [7:0]  ey_q;
  logic        s_q;
  logic        sp_q;
  logic [31:0] sr_q;
  logic [4:0]  sf_q;

  logic        x_nan, y_nan, x_inf, y_inf;
  logic        x_zero, y_zero, x_snan, y_snan;
  logic        s_c, sp_c;
  logic [31:0] sr_c;
  logic [4:0]  sf_c;

  logic [2:0]  trip;
  logic        one, two, neg;
  logic [49:0] mag, ppc, sa, sb, mj;
  logic [49:0] ps_n, pc_n;

  logic [47:0]        p;
  logic [9:0]         e0, e1;
  logic [22:0]        m0;
  logic               g, st, rnd, nx;
  logic [32:0]        r33;
  logic signed [9:0]  ef;
  logic [22:0]        mf;
  logic [31:0]        nr;
  logic [4:0]         nf;

  assign busy = (cnt != C_IDLE);

  // operand classification and special-case result, evaluated at accept
  always_comb begin
    x_nan  = (&x[30:23]) & (|x[22:0]);
    y_nan  = (&y[30:23]) & (|y[22:0]);
    x_inf  = (&x[30:23]) & ~(|x[22:0]);
    y_inf  = (&y[30:23]) & ~(|y[22:0]);
    x_zero = ~(|x[30:23]);
    y_zero = ~(|y[30:23]);
    x_snan = x_nan & ~x[22];
    y_snan = y_nan & ~y[22];
    s_c    = x[31] ^ y[31];
    sp_c   = x_nan | y_nan | x_inf | y_inf | x_zero | y_zero;
    sr_c   = 32'd0;
    sf_c   = 5'd0;
    if (x_nan) begin
      sr_c = x | 32'h0040_0000;
      sf_c = {x_snan | y_snan, 4'b0000};
    end else if (y_nan) begin
      sr_c = y | 32'h0040_0000;
      sf_c = {y_snan, 4'b0000};
    end else if ((x_inf & y_zero) | (x_zero & y_inf)) begin
      sr_c = 32'hFFC0_0000;
      sf_c = 5'b10000;
    end else if (x_inf | y_inf) begin
      sr_c = {s_c, 31'h7F80_0000};
    end else if (x_zero | y_zero) begin
      sr_c = {s_c, 31'd0};
    end
  end

  // Booth digit select and one carry-save step (MSB digit first)
  always_comb begin
    trip = mbr_q[26:24];
    one  = 1'b0;
    two  = 1'b0;
    neg  = 1'b0;
    case (trip)
      3'b001, 3'b010: one = 1'b1;
      3'b011: two = 1'b1;
      3'b100: begin
        two = 1'b1;
        neg = 1'b1;
      end
      3'b101, 3'b110: begin
        one = 1'b1;
        neg = 1'b1;
      end
      default: ;
    endcase
    mag = 50'd0;
    if (one)
      mag = {26'd0, ma_q};
    else if (two)
      mag = {25'd0, ma_q, 1'b0};
    ppc  = neg ? ~mag : mag;
    sa   = ps_q << 2;
    sb   = pc_q << 2;
    ps_n = sa ^ sb ^ ppc;
    mj   = (sa & sb) | (sa & ppc) | (sb & ppc);
    pc_n = (mj << 1) | {49'd0, neg};
  end

  // resolve carry-save, normalise, round-to-nearest-even, range check
  always_comb begin
    p  = ps_q[47:0] + pc_q[47:0];
    e0 = {2'b00, ex_q} + {2'b00, ey_q} - 10'd127;
    if (p[47]) begin
      m0 = p[46:24];
      g  = p[23];
      st = |p[22:0];
      e1 = e0 + 10'd1;
    end else begin
      m0 = p[45:23];
      g  = p[22];
      st = |p[21:0];
      e1 = e0;
    end
    rnd = g & (st | m0[0]);
    nx  = g | st;
    r33 = {e1, m0} + {32'd0, rnd};
    ef  = r33[32:23];
    mf  = r33[22:0];
    if (ef >= 10'sd255) begin
      nr = {s_q, 8'hFF, 23'd0};
      nf = 5'b00101;
    end else if (ef <= 10'sd0) begin
      nr = {s_q, 31'd0};
      nf = 5'b00011;
    end else begin
      nr = {s_q, ef[7:0], mf};
      nf = {4'b0000, nx};
    end
  end

  // sequencer, datapath registers and registered result
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= C_IDLE;
      valid <= 1'b0;
      rslt  <= 32'd0;
      flag  <= 5'd0;
      ma_q  <= 24'd0;
      mbr_q <= 27'd0;
      ps_q  <= 50'd0;
      pc_q  <= 50'd0;
      ex_q  <= 8'd0;
      ey_q  <= 8'd0;
      s_q   <= 1'b0;
      sp_q  <= 1'b0;
      sr_q  <= 32'd0;
      sf_q  <= 5'd0;
    end else begin
      valid <= 1'b0;
      unique case (1'b1)
        (cnt == C_IDLE): begin
          if (req) begin
            ma_q  <= {1'b1, x[22:0]};
            mbr_q <= {2'b00, 1'b1, y[22:0], 1'b0};
            ps_q  <= 50'd0;
            pc_q  <= 50'd0;
            ex_q  <= x[30:23];
            ey_q  <= y[30:23];
            s_q   <= s_c;
            sp_q  <= sp_c;
            sr_q  <= sr_c;
            sf_q  <= sf_c;
            cnt   <= 4'd1;
          end
        end
        (cnt != C_IDLE && cnt <= C_LAST): begin
          ps_q  <= ps_n;
          pc_q  <= pc_n;
          mbr_q <= {mbr_q[24:0], 2'b00};
          cnt   <= cnt + 4'd1;
`ifdef FMUL_EARLY_OUT_EN
          if (cnt == 4'd1 && sp_q) begin
            cnt   <= C_DONE;
            valid <= 1'b1;
            rslt  <= sr_q;
            flag  <= sf_q;
          end
`endif
        end
        (cnt == C_NORM): begin
          cnt   <= C_DONE;
          valid <= 1'b1;
          rslt  <= sp_q ? sr_q : nr;
          flag  <= sp_q ? sf_q : nf;
        end
        (cnt == C_DONE): begin
          cnt <= C_IDLE;
        end
      endcase
    end
  end

endmodule
